// File: rtl/beam_pkg.sv
// Shared types for the beam_combiner receive-path arbiter: source count,
// arbitration modes and FSM state encoding.
package beam_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        MODE_RR   = 2'd0,
        MODE_SRC0 = 2'd1,
        MODE_SRC1 = 2'd2,
        MODE_SRC2 = 2'd3
    } mode_t;

    // One-hot so a corrupted state register decodes to neither state
    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        LOCKED = 2'b10
    } arb_state_t;

    function automatic mode_t sel_to_mode(input logic [1:0] sel);
        case (sel)
            2'b01:   return MODE_SRC0;
            2'b10:   return MODE_SRC1;
            2'b11:   return MODE_SRC2;
            default: return MODE_RR;
        endcase
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry registered AXI4-Stream slice. Input ready depends only on the
// skid register, so downstream ready never reaches upstream combinationally.
module axis_skid_slice #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         r_out_vld;
    logic         r_skid_vld;

    assign o_ready = ~r_skid_vld;
    assign o_data  = r_out;
    assign o_valid = r_out_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_out_vld || i_ready) begin
            // Output register free this cycle: refill from skid first to keep order
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= i_valid;
                if (i_valid) r_out <= i_data;
            end
        end else if (i_valid && !r_skid_vld) begin
            r_skid     <= i_data;
            r_skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/beam_combiner.sv
// Packet-level 3:1 AXI4-Stream arbiter: round-robin or fixed source, switches
// only at tlast, tags beats with source index, counts packets per source.
module beam_combiner
    import beam_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        src_sel,
    input  logic [DWIDTH-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    input  logic [DWIDTH-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tlast,
    input  logic [DWIDTH-1:0] s2_axis_tdata,
    input  logic              s2_axis_tvalid,
    output logic              s2_axis_tready,
    input  logic              s2_axis_tlast,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [1:0]        m_axis_tid,
    output logic              busy,
    output logic [CNTW-1:0]   pkt_cnt0,
    output logic [CNTW-1:0]   pkt_cnt1,
    output logic [CNTW-1:0]   pkt_cnt2
);

    localparam int SW = DWIDTH + 3;

    logic [NUM_SRC-1:0]             w_valid;
    logic [NUM_SRC-1:0]             w_last;
    logic [NUM_SRC-1:0][DWIDTH-1:0] w_data;
    logic [NUM_SRC-1:0][CNTW-1:0]   r_cnt;

    arb_state_t r_state, w_state_nxt;
    mode_t      r_mode, w_mode_nxt, w_mode_in;
    logic [1:0] r_grant, w_grant_nxt;
    logic [1:0] r_rr_ptr, w_rr_nxt;
    logic [1:0] w_pick, w_idx;
    logic [2:0] w_sum;
    logic       w_found, w_grant_ok, w_lock;
    logic       w_sl_valid, w_sl_ready, w_xfer, w_eop;
    logic [SW-1:0] w_sl_in, w_sl_out;

    assign w_valid = {s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign w_last  = {s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};
    assign w_data  = {s2_axis_tdata, s1_axis_tdata, s0_axis_tdata};

    // Candidate grant; only acted on in IDLE. Loop runs from lowest priority
    // upward so the last hit is the first valid source at or after rr_ptr.
    always_comb begin
        w_mode_in = sel_to_mode(src_sel);
        w_found   = 1'b0;
        w_pick    = 2'd0;
        w_sum     = 3'd0;
        w_idx     = 2'd0;
        if (w_mode_in == MODE_RR) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                w_sum = {1'b0, r_rr_ptr} + 3'(i);
                w_idx = (w_sum >= 3'(NUM_SRC)) ? 2'(w_sum - 3'(NUM_SRC)) : w_sum[1:0];
                if (w_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_pick  = w_idx;
                end
            end
        end else begin
            w_pick  = 2'(w_mode_in) - 2'd1;
            w_found = w_valid[w_pick];
        end
    end

    assign w_grant_ok = (r_grant != 2'd3);
    assign w_lock     = (r_state == LOCKED) && w_grant_ok;
    assign w_sl_valid = w_lock && w_valid[r_grant];
    assign w_xfer     = w_sl_valid && w_sl_ready;
    assign w_eop      = w_xfer && w_last[r_grant];
    assign w_sl_in    = {r_grant, w_last[r_grant], w_data[r_grant]};

    assign s0_axis_tready = w_lock && (r_grant == 2'd0) && w_sl_ready;
    assign s1_axis_tready = w_lock && (r_grant == 2'd1) && w_sl_ready;
    assign s2_axis_tready = w_lock && (r_grant == 2'd2) && w_sl_ready;
    assign busy           = (r_state == LOCKED);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_mode_nxt  = r_mode;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = w_pick;
                    w_mode_nxt  = w_mode_in;
                end
            end
            LOCKED: begin
                if (!w_grant_ok) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'd0;
                end else if (w_eop) begin
                    w_state_nxt = IDLE;
                    if (r_mode == MODE_RR)
                        w_rr_nxt = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= 2'd0;
            r_mode   <= MODE_RR;
            r_rr_ptr <= 2'd0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_mode   <= w_mode_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (w_eop) r_cnt[r_grant] <= r_cnt[r_grant] + CNTW'(1);
        end
    end

    assign pkt_cnt0 = r_cnt[0];
    assign pkt_cnt1 = r_cnt[1];
    assign pkt_cnt2 = r_cnt[2];

    axis_skid_slice #(.W(SW)) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_sl_in),
        .i_valid (w_sl_valid),
        .o_ready (w_sl_ready),
        .o_data  (w_sl_out),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = w_sl_out;

endmodule

// File: tb/tb_beam_combiner.sv
// Scoreboard bench for beam_combiner: packet-level arbitration model feeds an
// expected-beat queue, a negedge monitor pops and compares every output beat.
module tb_beam_combiner;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
    typedef struct packed { logic [1:0] tid; logic last; logic [DW-1:0] data; } obeat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    src_sel = 2'b00;
    logic [DW-1:0] sd [3];
    logic [2:0]    sv = '0;
    logic [2:0]    sl = '0;
    logic [2:0]    sr;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, busy;
    logic          m_tready = 1'b1;
    logic [1:0]    m_tid;
    logic [CW-1:0] cnt0, cnt1, cnt2;

    beat_t  sq  [3][$];
    beat_t  mbq [3][$];
    int     mpl [3][$];
    obeat_t expq[$];
    int     mcnt [3];
    int     mptr = 0;
    int     mmode = 0;
    int     rdy_mode = 0;
    int     n_cmp = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    beam_combiner #(.DWIDTH(DW), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .src_sel(src_sel),
        .s0_axis_tdata(sd[0]), .s0_axis_tvalid(sv[0]), .s0_axis_tready(sr[0]), .s0_axis_tlast(sl[0]),
        .s1_axis_tdata(sd[1]), .s1_axis_tvalid(sv[1]), .s1_axis_tready(sr[1]), .s1_axis_tlast(sl[1]),
        .s2_axis_tdata(sd[2]), .s2_axis_tvalid(sv[2]), .s2_axis_tready(sr[2]), .s2_axis_tlast(sl[2]),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .busy(busy),
        .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .pkt_cnt2(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Source and sink drivers: retire beats on handshake, present next head
    always begin
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            if (!rst && sv[k] && sr[k] && sq[k].size() > 0) void'(sq[k].pop_front());
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sq[k].size() > 0) begin
                sv[k] = 1'b1; sd[k] = sq[k][0].data; sl[k] = sq[k][0].last;
            end else begin
                sv[k] = 1'b0; sd[k] = '0; sl[k] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 99) < 30);
        endcase
    end

    logic   stall_q = 1'b0;
    obeat_t held, mon_e;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_beat", 64'({m_tid, m_tlast, m_tdata}), 64'(held));
            end
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got tid=%0d data=%0h with nothing expected", m_tid, m_tdata);
                end else begin
                    mon_e = expq.pop_front();
                    chk("out_beat", 64'({m_tid, m_tlast, m_tdata}), 64'(mon_e));
                end
            end
            stall_q = m_tvalid && !m_tready;
            held    = {m_tid, m_tlast, m_tdata};
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic add_pkt(input int k, input int len, input bit rnd);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = rnd ? DW'($urandom()) : DW'(k * 16 + b);
            x.last = (b == len - 1);
            sq[k].push_back(x);
            mbq[k].push_back(x);
        end
        mpl[k].push_back(len);
    endtask

    task automatic expect_pkt(input int k);
        int     len;
        beat_t  b;
        obeat_t o;
        len = mpl[k].pop_front();
        repeat (len) begin
            b = mbq[k].pop_front();
            o.tid = 2'(k); o.last = b.last; o.data = b.data;
            expq.push_back(o);
        end
        mcnt[k]++;
    endtask

    // Packet-level arbitration over everything currently queued
    task automatic plan();
        int k;
        while (1) begin
            k = -1;
            if (mmode == 0) begin
                for (int i = 0; i < 3; i++)
                    if (k < 0 && mpl[(mptr + i) % 3].size() > 0) k = (mptr + i) % 3;
            end else if (mpl[mmode - 1].size() > 0) begin
                k = mmode - 1;
            end
            if (k < 0) break;
            expect_pkt(k);
            if (mmode == 0) mptr = (k + 1) % 3;
        end
    endtask

    task automatic rst_begin();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sq[k].delete(); mbq[k].delete(); mpl[k].delete(); mcnt[k] = 0;
        end
        expq.delete();
        mptr = 0;
    endtask

    task automatic rst_end(input int cyc);
        repeat (cyc) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin tick(); n++; end
        n_cmp++;
        if (expq.size() > 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats still pending, required 0 after %0d cycles", name, expq.size(), budget);
        end
        repeat (4) tick();
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_cnt0"}, 64'(cnt0), 64'(mcnt[0]));
        chk({name, "_cnt1"}, 64'(cnt1), 64'(mcnt[1]));
        chk({name, "_cnt2"}, 64'(cnt2), 64'(mcnt[2]));
    endtask

    initial begin
        int first, last, nv, nl, cyc, bad;

        // Reset with every source valid, then round robin over 4-beat packets
        rst_begin();
        add_pkt(0, 4, 0); add_pkt(1, 4, 0); add_pkt(2, 4, 0); add_pkt(0, 4, 0);
        plan();
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_tready", 64'(sr), 64'd0);
            chk("rst_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_cnt", 64'({cnt0, cnt1, cnt2}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_tready", 64'(sr), 64'b001);
        chk("first_no_valid", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("first_latency", 64'({m_tvalid, m_tid, m_tdata}), {31'd0, 1'b1, 2'd0, 32'h0});
        first = -1; last = 0; nv = 0; nl = 0; cyc = 0;
        while (nl < 4 && cyc < 100) begin
            if (m_tvalid) begin
                if (first < 0) first = cyc;
                last = cyc; nv++;
                if (m_tlast && m_tready) nl++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("rr_valid_beats", 64'(nv), 64'd16);
        chk("rr_span_one_bubble", 64'(last - first + 1), 64'd19);
        tick();
        drain("rr", 50);
        chk_cnt("rr");

        // Round robin skip: only src2 has data
        rst_begin();
        add_pkt(2, 3, 1); add_pkt(2, 5, 1);
        plan();
        rst_end(2);
        @(posedge clk); @(negedge clk);
        chk("skip_first_grant", 64'(sr), 64'b100);
        tick();
        drain("skip", 60);
        chk_cnt("skip");

        // Fixed src1 with all sources valid
        rst_begin();
        src_sel = 2'b10; mmode = 2;
        for (int k = 0; k < 3; k++) begin add_pkt(k, 4, 1); add_pkt(k, 4, 1); end
        plan();
        rst_end(2);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (sr[0] || sr[2]) bad++;
        end
        chk("fixed_other_tready", 64'(bad), 64'd0);
        tick();
        drain("fixed", 20);
        chk_cnt("fixed");

        // Backpressure: toggling then random 30% ready
        rst_begin();
        src_sel = 2'b00; mmode = 0; rdy_mode = 1;
        for (int k = 0; k < 3; k++)
            repeat (3) add_pkt(k, $urandom_range(1, 5), 1);
        plan();
        rst_end(2);
        drain("toggle", 1000);
        chk_cnt("toggle");
        rdy_mode = 2;
        repeat (10) add_pkt($urandom_range(0, 2), $urandom_range(1, 6), 1);
        plan();
        drain("random", 3000);
        chk_cnt("random");
        rdy_mode = 0;
        repeat (4) tick();

        // src_sel 00 -> 11 mid-packet on src0
        rst_begin();
        src_sel = 2'b00;
        add_pkt(0, 4, 0); add_pkt(1, 4, 0); add_pkt(2, 4, 0);
        expect_pkt(0); expect_pkt(2);
        rst_end(2);
        cyc = 0;
        while (sq[0].size() > 2 && cyc < 50) begin tick(); cyc++; end
        src_sel = 2'b11;
        drain("selchg", 50);
        chk("selchg_src1_untouched", 64'(sq[1].size()), 64'd4);
        chk_cnt("selchg");

        // Reset in the middle of a packet
        rst_begin();
        src_sel = 2'b00; mmode = 0;
        add_pkt(0, 6, 1);
        plan();
        rst_end(2);
        cyc = 0;
        while (sq[0].size() > 4 && cyc < 50) begin tick(); cyc++; end
        rst_begin();
        @(posedge clk); @(negedge clk);
        chk("midrst_out", 64'({m_tvalid, m_tlast, m_tid, m_tdata}), 64'd0);
        chk("midrst_busy", 64'({busy, sr}), 64'd0);
        chk("midrst_cnt", 64'({cnt0, cnt1, cnt2}), 64'd0);
        add_pkt(1, 3, 1);
        plan();
        rst_end(1);
        drain("midrst", 50);
        chk_cnt("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
